// File: rtl/syst_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply engine.
package syst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Accumulator width that holds the sum of n full-scale width x width products.
  function automatic int calc_acc_w(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/syst_acc_pe.sv
// One output-stationary processing element: forwards operands east/south
// and accumulates their product in place.
module syst_acc_pe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] s,
  output logic [ACC_W-1:0] acc
);

  logic [2*WIDTH-1:0] w_prod;

  assign w_prod = {{WIDTH{1'b0}}, w} * {{WIDTH{1'b0}}, n};

  // Forward operands and accumulate; clr starts a fresh job's sum.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e   <= '0;
      s   <= '0;
      acc <= '0;
    end else begin
      e <= w;
      s <= n;
      if (clr) acc <= '0;
      else     acc <= acc + ACC_W'(w_prod);
    end
  end

endmodule

// File: rtl/syst_mm_ctrl.sv
// N x N output-stationary matrix-multiply engine: operand skew, PE grid,
// and the job controller that loads beats, drains the grid and streams rows.
module syst_mm_ctrl
  import syst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int ACC_W = calc_acc_w(WIDTH, N)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0][WIDTH-1:0]    a_col,
  input  logic [N-1:0][WIDTH-1:0]    b_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0][ACC_W-1:0]    out_row,
  output logic                       busy
);

  localparam int BCW = $clog2(N);
  localparam int DCW = $clog2(2 * N);
  localparam logic [BCW-1:0] LAST_BEAT  = BCW'(N - 1);
  localparam logic [BCW-1:0] LAST_ROW   = BCW'(N - 1);
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'(2 * N - 2);

  state_t         r_state;
  logic [BCW-1:0] r_beat_cnt;
  logic [DCW-1:0] r_drain_cnt;
  logic [BCW-1:0] r_row_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic           w_accept;
  logic           w_clr;

  logic [WIDTH-1:0] w_h [N][N];
  logic [WIDTH-1:0] w_v [N][N];
  logic [ACC_W-1:0] w_acc [N][N];
  logic [WIDTH-1:0] w_east_unused [N];
  logic [WIDTH-1:0] w_south_unused [N];

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  assign w_accept = in_valid && r_in_ready;
  // The first beat of a job wipes the previous job's sums on the same edge.
  assign w_clr    = w_accept && (r_state == IDLE);

  // Row i of A: edge register plus i extra stages onto the west edge.
  for (genvar i = 0; i < N; i++) begin : g_askew
    logic [WIDTH-1:0] r_dly [i+1];
    // Capture the beat (or a zero bubble) and shift the skew chain.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int d = 0; d <= i; d++) r_dly[d] <= '0;
      end else begin
        r_dly[0] <= w_accept ? a_col[i] : '0;
        for (int d = 1; d <= i; d++) r_dly[d] <= r_dly[d-1];
      end
    end
    assign w_h[i][0] = r_dly[i];
  end

  // Column j of B: edge register plus j extra stages onto the north edge.
  for (genvar j = 0; j < N; j++) begin : g_bskew
    logic [WIDTH-1:0] r_dly [j+1];
    // Capture the beat (or a zero bubble) and shift the skew chain.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int d = 0; d <= j; d++) r_dly[d] <= '0;
      end else begin
        r_dly[0] <= w_accept ? b_row[j] : '0;
        for (int d = 1; d <= j; d++) r_dly[d] <= r_dly[d-1];
      end
    end
    assign w_v[0][j] = r_dly[j];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [WIDTH-1:0] w_e;
      logic [WIDTH-1:0] w_s;

      syst_acc_pe #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_clr),
        .w    (w_h[i][j]),
        .n    (w_v[i][j]),
        .e    (w_e),
        .s    (w_s),
        .acc  (w_acc[i][j])
      );

      if (j < N - 1) begin : g_e_link
        assign w_h[i][j+1] = w_e;
      end else begin : g_e_edge
        assign w_east_unused[i] = w_e;
      end

      if (i < N - 1) begin : g_s_link
        assign w_v[i+1][j] = w_s;
      end else begin : g_s_edge
        assign w_south_unused[j] = w_s;
      end
    end
  end

  // Present the selected accumulator row only while a row is offered.
  always_comb begin
    for (int j = 0; j < N; j++) out_row[j] = '0;
    if (r_out_valid) begin
      for (int j = 0; j < N; j++) out_row[j] = w_acc[r_row_cnt][j];
    end
  end

  // Job controller: load N beats, drain the grid, stream N result rows.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_row_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state    <= LOAD;
            r_beat_cnt <= BCW'(1);
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_state     <= DRAIN;
              r_drain_cnt <= '0;
              r_in_ready  <= 1'b0;
            end else begin
              r_beat_cnt <= r_beat_cnt + BCW'(1);
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt == LAST_DRAIN) begin
            r_state     <= OUT;
            r_row_cnt   <= '0;
            r_out_valid <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            if (r_row_cnt == LAST_ROW) begin
              r_state     <= IDLE;
              r_beat_cnt  <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_row_cnt <= r_row_cnt + BCW'(1);
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syst_mm_ctrl.sv
// Bench for syst_mm_ctrl: jobs push model-computed result rows into a
// scoreboard queue; rows leaving the DUT are popped and compared.
module tb_syst_mm_ctrl;

  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int ACC_W = 18;

  typedef logic [N-1:0][ACC_W-1:0] row_t;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b0;
  logic                    in_ready;
  logic                    out_valid;
  logic                    busy;
  logic [N-1:0][WIDTH-1:0] a_col = '0;
  logic [N-1:0][WIDTH-1:0] b_row = '0;
  row_t                    out_row;

  row_t sb[$];
  int   A [N][N];
  int   B [N][N];
  int   checks   = 0;
  int   failures = 0;

  syst_mm_ctrl #(
    .WIDTH (WIDTH),
    .N     (N),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col     (a_col),
    .b_row     (b_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic push_expected();
    row_t e;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        int sum;
        sum = 0;
        for (int k = 0; k < N; k++) sum += A[r][k] * B[k][j];
        e[j] = ACC_W'(sum);
      end
      sb.push_back(e);
    end
  endtask

  task automatic set_ident_a();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) A[i][j] = (i == j) ? 1 : 0;
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = int'($urandom_range(0, 255));
        B[i][j] = int'($urandom_range(0, 255));
      end
  endtask

  // Drive one job; called at a negedge, returns at the negedge after the last accept.
  task automatic send_job(input int gap);
    push_expected();
    for (int k = 0; k < N; k++) begin
      int t;
      for (int i = 0; i < N; i++) begin
        a_col[i] = WIDTH'(A[i][k]);
        b_row[i] = WIDTH'(B[k][i]);
      end
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: beat %0d in_ready=%0b required 1", k, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      a_col = '0;
      b_row = '0;
      if (k < N - 1) begin
        repeat (gap) begin
          checks++;
          if (in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bubble_ready: in_ready=%0b busy=%0b required 1 1", in_ready, busy);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  // Collect N rows, optionally stalling each one, then confirm return to IDLE.
  task automatic collect_job(input int stall);
    for (int r = 0; r < N; r++) begin
      int   t;
      row_t hold;
      row_t exp;
      t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL out_timeout: row %0d out_valid=%0b required 1", r, out_valid);
        return;
      end
      hold = out_row;
      out_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_row !== hold) begin
          failures++;
          $display("FAIL stall_hold: row %0d out_valid=%0b out_row=%h required 1 %h",
                   r, out_valid, out_row, hold);
        end
      end
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      checks++;
      if (out_row !== exp) begin
        failures++;
        $display("FAIL row_data: row %0d got %h required %h", r, out_row, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_out: busy=%0b out_valid=%0b in_ready=%0b required 0 0 1",
               busy, out_valid, in_ready);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready: got %0b required 1", tag, in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_out_valid: got %0b required 0", tag, out_valid);
    end
    checks++;
    if (out_row !== '0) begin
      failures++;
      $display("FAIL %s_out_row: got %h required 0", tag, out_row);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: got %0b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int cnt;
    set_ident_a();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) B[i][j] = i * N + j + 1;
    send_job(0);
    cnt = 1;
    while (!out_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != 2 * N) begin
      failures++;
      $display("FAIL latency: out_valid after %0d cycles required %0d", cnt, 2 * N);
    end
    collect_job(0);
  endtask

  task automatic test_max();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 255;
        B[i][j] = 255;
      end
    send_job(0);
    collect_job(0);
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = i * N + j + 1;
        B[i][j] = 9 - (i * N + j);
      end
    send_job(0);
    collect_job(0);
    send_job(2);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_last: in_ready=%0b busy=%0b required 0 1", in_ready, busy);
    end
    collect_job(0);
  endtask

  task automatic test_backpressure();
    set_random();
    send_job(0);
    collect_job(3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 1;
        B[i][j] = 1;
      end
    send_job(0);
    collect_job(0);
    set_ident_a();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) B[i][j] = (i == j) ? 2 : 0;
    send_job(0);
    collect_job(0);
  endtask

  task automatic test_reset_mid_drain();
    set_random();
    send_job(0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    rstn = 1'b1;
    sb.delete();
    @(negedge clk);
    set_random();
    send_job(1);
    collect_job(1);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max();
    test_bubbles();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/syst_mm_ctrl.md
Name: syst_mm_ctrl

Overview:
- Output-stationary N x N matrix-multiply engine: controller plus its own grid of accumulating processing elements.
- Accepts one job as N operand beats (column k of A, row k of B).
- Skews operands onto the grid edges, drains the pipeline, then streams C = A*B out one row per beat.
- Sits between an operand fetch unit (valid/ready producer) and a result writer (valid/ready consumer).

Parameters:
WIDTH, 8, operand width (unsigned)
N, 3, matrix dimension / grid size (N >= 2)
ACC_W, 2*WIDTH+$clog2(N), accumulator and result width

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
in_valid  in  1  operand beat valid
in_ready  out  1  controller can accept a beat
a_col  in  N x WIDTH  a_col[i] = A[i][k] for beat k
b_row  in  N x WIDTH  b_row[j] = B[k][j] for beat k
out_valid  out  1  result row valid
out_ready  in  1  consumer accepts row
out_row  out  N x ACC_W  out_row[j] = C[r][j] for output beat r
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rstn=0 at posedge), overriding everything including mid-job:
  - state=IDLE; all counters, skew registers, PE forwarding registers and accumulators cleared to 0.
  - After reset: in_ready=1, out_valid=0, out_row=0, busy=0.
- States and transitions:
  - IDLE: in_ready=1. Beat accepted (in_valid&in_ready) -> LOAD, beat_cnt=1, all accumulators cleared in that same edge, beat 0 enters the skew stage.
  - LOAD: in_ready=1.
    - Each accepted beat enters the skew stage and increments beat_cnt.
    - A cycle without an accepted beat injects zeros on all edges (bubble; contributes 0 to every sum).
    - Accepting beat N-1 -> DRAIN, drain_cnt=0.
  - DRAIN: in_ready=0, zeros injected. Lasts exactly 2N-1 cycles, then -> OUT, row_cnt=0.
  - OUT: in_ready=0, out_valid=1, out_row = accumulators of row row_cnt.
    - out_valid&out_ready -> row_cnt++.
    - Acceptance of row N-1 -> IDLE, out_valid=0 the next cycle.
    - out_row is held stable while out_valid&!out_ready.
- Skew and timing:
  - Edge input register, then row i of A delayed by i extra registers onto the west edge of PE(i,0).
  - Column j of B likewise delayed by j extra registers onto the north edge of PE(0,j).
  - Each PE registers w->e and n->s, and does acc <= acc + w*n every cycle.
  - A beat accepted at edge t reaches PE(i,j) at cycle t+1+i+j. The last product lands in PE(N-1,N-1) visible at cycle t+2N.
  - Hence out_valid first rises exactly 2N cycles after the edge accepting beat N-1 (N=3: 6 cycles).
- Arithmetic: unsigned; product 2*WIDTH bits, zero-extended into ACC_W; no overflow possible for N beats.
- Corner cases:
  - In OUT, in_valid is ignored (not accepted) even in the cycle row N-1 is accepted. The next job can start in the following IDLE cycle.
  - Back-to-back jobs never mix: accumulators clear on the first accept.
  - in_valid held low indefinitely in LOAD keeps the controller in LOAD; the result is unaffected.

Decomposition:
- Package syst_pkg: state enum (IDLE, LOAD, DRAIN, OUT) and a function computing ACC_W from WIDTH and N.
- Sub-module syst_acc_pe: one accumulating PE with ports clk, rstn, clr, w, n, e, s, acc. Instantiated N x N via generate.
- Skew registers, counters and FSM stay in syst_mm_ctrl.

Test Plan:
- Identity x B: N=3, A=I, B=[[1,2,3],[4,5,6],[7,8,9]], in_valid held high -> out rows [1,2,3],[4,5,6],[7,8,9]; out_valid rises 6 cycles after beat 2 accepted.
- Max values: all A,B=255 -> every C element 195075 (18-bit ACC_W); no wrap.
- Input bubbles: same job with in_valid low 2 cycles between each beat -> identical C. in_ready stays 1 through LOAD and drops only after beat 2.
- Output backpressure: out_ready low 3 cycles on each row -> out_row stable while stalled, rows in order 0..2, IDLE after the third accept.
- Back-to-back: job 1 = all ones (C all 3), then immediately job 2 = A=I, B=2I -> C=2I; no residue from job 1.
- Reset mid-DRAIN: rstn low one cycle -> next cycle busy=0, in_ready=1, out_valid=0. A fresh job then produces correct C.
